// File: rtl/vcpu_pkg.sv
// Shared opcode and flag-position constants for the vcpu execute-stage ALU.
package vcpu_pkg;

  localparam logic [3:0] op_ADD  = 4'd0;
  localparam logic [3:0] op_ADDX = 4'd1;
  localparam logic [3:0] op_SUB  = 4'd2;
  localparam logic [3:0] op_SUBX = 4'd3;
  localparam logic [3:0] op_AND  = 4'd4;
  localparam logic [3:0] op_OR   = 4'd5;
  localparam logic [3:0] op_EOR  = 4'd6;
  localparam logic [3:0] op_NEG  = 4'd7;
  localparam logic [3:0] op_LSx  = 4'd8;
  localparam logic [3:0] op_ASx  = 4'd9;
  localparam logic [3:0] op_ROx  = 4'd10;
  localparam logic [3:0] op_ROXx = 4'd11;
  localparam logic [3:0] op_CMP  = 4'd12;
  localparam logic [3:0] op_NEGX = 4'd13;
  localparam logic [3:0] op_NOT  = 4'd14;
  localparam logic [3:0] op_MOVE = 4'd15;

  localparam int bitpos_X = 4;
  localparam int bitpos_N = 3;
  localparam int bitpos_Z = 2;
  localparam int bitpos_V = 1;
  localparam int bitpos_C = 0;

endpackage

// File: rtl/vcpu_alu_shifter.sv
// Combinational shift/rotate unit for the vcpu ALU: LSx, ASx, ROx and ROXx.
module vcpu_alu_shifter
  import vcpu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [5:0]   count,
  input  logic         left,
  input  logic         x_in,
  output logic [N-1:0] res,
  output logic         c,
  output logic         x,
  output logic         v
);

  logic [2*N-1:0] lsl_w, lsr_w, asr_w, rot_w;
  logic [2*N+1:0] rox_w, rox_dbl;
  logic [N-1:0]   asl_mask, adj_diff;
  int unsigned    ro_amt, rox_amt;

  // Double-width shifts keep the last bit shifted out at a fixed position
  always_comb begin
    lsl_w    = {{N{1'b0}}, a} << count;
    lsr_w    = {a, {N{1'b0}}} >> count;
    asr_w    = $signed({a, {N{1'b0}}}) >>> count;
    ro_amt   = 32'(count) % N;
    rox_amt  = 32'(count) % (N + 1);
    rot_w    = left ? ({a, a} << ro_amt) : ({a, a} >> ro_amt);
    rox_dbl  = {x_in, a, x_in, a};
    rox_w    = left ? (rox_dbl << rox_amt) : (rox_dbl >> rox_amt);
    asl_mask = ~({N{1'b1}} >> count);
    adj_diff = a ^ (a << 1);

    res = '0;
    c   = 1'b0;
    x   = x_in;
    v   = 1'b0;
    case (op)
      op_LSx, op_ASx: begin
        if (left) begin
          res = lsl_w[N-1:0];
          c   = lsl_w[N];
          if (op == op_ASx)
            v = |(adj_diff & asl_mask);
        end else if (op == op_ASx) begin
          res = asr_w[2*N-1:N];
          c   = asr_w[N-1];
        end else begin
          res = lsr_w[2*N-1:N];
          c   = lsr_w[N-1];
        end
        x = (count == 6'd0) ? x_in : c;
      end
      op_ROx: begin
        res = left ? rot_w[2*N-1:N] : rot_w[N-1:0];
        c   = (count == 6'd0) ? 1'b0 : (left ? res[0] : res[N-1]);
      end
      op_ROXx: begin
        // Extend bit rides in the rotation as bit N of a (N+1)-bit word
        res = left ? rox_w[2*N:N+1] : rox_w[N-1:0];
        c   = left ? rox_w[2*N+1] : rox_w[N];
        x   = c;
      end
      default: begin
        res = '0;
      end
    endcase
  end

endmodule

// File: rtl/vcpu_alu.sv
// 68k-style registered ALU for the vcpu execute stage.
// Define ALU_ZSTICKY_EN to make ADDX/SUBX/NEGX chain Z across multi-precision ops.
module vcpu_alu
  import vcpu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_A,
  input  logic [N-1:0] in_B,
  input  logic [3:0]   in_OP,
  input  logic         in_X,
  output logic [4:0]   out_XNZVC,
  output logic [N-1:0] out_RES
);

  logic [N:0]   sum, diff, negd;
  logic [N-1:0] sh_res, nxt_res, nz_src;
  logic         sh_c, sh_x, sh_v;
  logic         add_v, sub_v, neg_v, res_zero;
  logic         flag_x, flag_c, flag_v, flag_z;
  logic [4:0]   nxt_flags;

  vcpu_alu_shifter #(.N(N)) u_shifter (
    .op    (in_OP),
    .a     (in_A),
    .count (in_B[5:0]),
    .left  (in_B[7]),
    .x_in  (in_X),
    .res   (sh_res),
    .c     (sh_c),
    .x     (sh_x),
    .v     (sh_v)
  );

  // Bit N of each result is the carry (add) or borrow (sub/neg) out
  assign sum   = {1'b0, in_A} + {1'b0, in_B} + {{N{1'b0}}, (in_OP == op_ADDX) & in_X};
  assign diff  = {1'b0, in_A} - {1'b0, in_B} - {{N{1'b0}}, (in_OP == op_SUBX) & in_X};
  assign negd  = {(N+1){1'b0}} - {1'b0, in_A} - {{N{1'b0}}, (in_OP == op_NEGX) & in_X};
  assign add_v = (in_A[N-1] == in_B[N-1]) && (sum[N-1] != in_A[N-1]);
  assign sub_v = (in_A[N-1] != in_B[N-1]) && (diff[N-1] != in_A[N-1]);
  assign neg_v = (in_A == {1'b1, {(N-1){1'b0}}});

  always_comb begin
    nxt_res = '0;
    flag_x  = in_X;
    flag_c  = 1'b0;
    flag_v  = 1'b0;
    case (in_OP)
      op_ADD, op_ADDX: begin
        nxt_res = sum[N-1:0];
        flag_c  = sum[N];
        flag_x  = sum[N];
        flag_v  = add_v;
      end
      op_SUB, op_SUBX: begin
        nxt_res = diff[N-1:0];
        flag_c  = diff[N];
        flag_x  = diff[N];
        flag_v  = sub_v;
      end
      op_CMP: begin
        nxt_res = in_A;
        flag_c  = diff[N];
        flag_v  = sub_v;
      end
      op_NEG, op_NEGX: begin
        nxt_res = negd[N-1:0];
        flag_c  = negd[N];
        flag_x  = negd[N];
        flag_v  = neg_v;
      end
      op_AND:  nxt_res = in_A & in_B;
      op_OR:   nxt_res = in_A | in_B;
      op_EOR:  nxt_res = in_A ^ in_B;
      op_NOT:  nxt_res = ~in_A;
      op_MOVE: nxt_res = in_B;
      op_LSx, op_ASx, op_ROx, op_ROXx: begin
        nxt_res = sh_res;
        flag_c  = sh_c;
        flag_x  = sh_x;
        flag_v  = sh_v;
      end
      default: nxt_res = '0;
    endcase

    // CMP reports N/Z of the difference while passing A through
    nz_src   = (in_OP == op_CMP) ? diff[N-1:0] : nxt_res;
    res_zero = (nz_src == '0);
`ifdef ALU_ZSTICKY_EN
    if (in_OP == op_ADDX || in_OP == op_SUBX || in_OP == op_NEGX)
      flag_z = out_XNZVC[bitpos_Z] & res_zero;
    else
      flag_z = res_zero;
`else
    flag_z = res_zero;
`endif

    nxt_flags           = '0;
    nxt_flags[bitpos_X] = flag_x;
    nxt_flags[bitpos_N] = nz_src[N-1];
    nxt_flags[bitpos_Z] = flag_z;
    nxt_flags[bitpos_V] = flag_v;
    nxt_flags[bitpos_C] = flag_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_RES   <= '0;
      out_XNZVC <= '0;
    end else begin
      out_RES   <= nxt_res;
      out_XNZVC <= nxt_flags;
    end
  end

endmodule

// File: tb/tb_vcpu_alu.sv
// Directed scoreboard bench for vcpu_alu (N=32); expectations follow ALU_ZSTICKY_EN.
module tb_vcpu_alu;
  import vcpu_pkg::*;

  localparam int W = 32;

  typedef struct {
    string          tag;
    logic [W-1:0]   res;
    logic [4:0]     flags;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_A, in_B;
  logic [3:0]   in_OP;
  logic         in_X;
  logic [4:0]   out_XNZVC;
  logic [W-1:0] out_RES;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  vcpu_alu #(.N(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_A      (in_A),
    .in_B      (in_B),
    .in_OP     (in_OP),
    .in_X      (in_X),
    .out_XNZVC (out_XNZVC),
    .out_RES   (out_RES)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input string tag, input logic rst, input logic [3:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b, input logic x,
                               input logic [W-1:0] eres, input logic [4:0] eflags);
    exp_t e;
    @(negedge clk);
    reset = rst;
    in_OP = op;
    in_A  = a;
    in_B  = b;
    in_X  = x;
    e.tag   = tag;
    e.res   = eres;
    e.flags = eflags;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
    end else begin
      e = sb.pop_front();
      checks++;
      assert (out_RES === e.res) else begin
        errors++;
        $error("[TB] FAIL %s RES: got %h, expected %h", e.tag, out_RES, e.res);
      end
      checks++;
      assert (out_XNZVC === e.flags) else begin
        errors++;
        $error("[TB] FAIL %s XNZVC: got %b, expected %b", e.tag, out_XNZVC, e.flags);
      end
    end
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic x,
                      input logic [W-1:0] eres, input logic [4:0] eflags);
    applyStimulus(tag, 1'b0, op, a, b, x, eres, eflags);
    checkOutput();
  endtask

  initial begin
    reset = 1'b1;
    in_OP = op_ADD;
    in_A  = 32'd5;
    in_B  = 32'd5;
    in_X  = 1'b1;

    applyStimulus("reset", 1'b1, op_ADD, 32'd5, 32'd5, 1'b1, 32'h0, 5'b00000);
    checkOutput();

    step("roxl_4",     op_ROXx, 32'h000008FF, 32'h84, 1'b0, 32'h00008FF0, 5'b00000);
    step("roxr_16",    op_ROXx, 32'h000008FF, 32'h10, 1'b0, 32'h11FE0000, 5'b00000);
    step("roxr_1",     op_ROXx, 32'h000008FF, 32'h01, 1'b0, 32'h0000047F, 5'b10001);
    step("roxr_0",     op_ROXx, 32'h000008FF, 32'h00, 1'b1, 32'h000008FF, 5'b10001);
    step("add_wrap",   op_ADD,  32'hFFFFFFFF, 32'h1,  1'b0, 32'h0,        5'b10101);
    step("sub_ovf",    op_SUB,  32'h80000000, 32'h1,  1'b0, 32'h7FFFFFFF, 5'b00010);
    step("asl_ovf",    op_ASx,  32'h40000000, 32'h82, 1'b0, 32'h0,        5'b10111);
    step("lsr_33",     op_LSx,  32'hFFFFFFFF, 32'h21, 1'b0, 32'h0,        5'b00100);
    step("and",        op_AND,  32'hF0F01234, 32'h0FF0FFFF, 1'b1, 32'h00F01234, 5'b10000);
    step("eor",        op_EOR,  32'hFFFF0000, 32'h0000FFFF, 1'b0, 32'hFFFFFFFF, 5'b01000);
    step("not",        op_NOT,  32'hFFFFFFFF, 32'h0,  1'b1, 32'h0,        5'b10100);
    step("move",       op_MOVE, 32'h0,        32'h80000000, 1'b0, 32'h80000000, 5'b01000);
    step("cmp",        op_CMP,  32'd5,        32'd7,  1'b0, 32'd5,        5'b01001);
    step("neg_min",    op_NEG,  32'h80000000, 32'h0,  1'b0, 32'h80000000, 5'b11011);
    step("negx_zero",  op_NEGX, 32'h0,        32'h0,  1'b1, 32'hFFFFFFFF, 5'b11001);
    step("subx",       op_SUBX, 32'h10,       32'h5,  1'b1, 32'h0000000A, 5'b00000);
    step("asr_4",      op_ASx,  32'h8000000F, 32'h04, 1'b0, 32'hF8000000, 5'b11001);
    step("asr_40",     op_ASx,  32'h80000000, 32'h28, 1'b0, 32'hFFFFFFFF, 5'b11001);
    step("rol_1",      op_ROx,  32'h80000001, 32'h81, 1'b0, 32'h00000003, 5'b00001);
    step("ror_1",      op_ROx,  32'h00000001, 32'h01, 1'b1, 32'h80000000, 5'b11001);
    step("lsl_0",      op_LSx,  32'h12345678, 32'h80, 1'b1, 32'h12345678, 5'b10000);
    step("lsr_b6",     op_LSx,  32'h000000F0, 32'h44, 1'b0, 32'h0000000F, 5'b00000);

    applyStimulus("reset_wins", 1'b1, op_MOVE, 32'h0, 32'hFFFF, 1'b1, 32'h0, 5'b00000);
    checkOutput();

    step("chain_add",  op_ADD,  32'h0, 32'h0, 1'b0, 32'h0, 5'b00100);
    step("chain_x0",   op_ADDX, 32'h0, 32'h0, 1'b0, 32'h0, 5'b00100);
    step("chain_x1",   op_ADDX, 32'h1, 32'h0, 1'b0, 32'h1, 5'b00000);
`ifdef ALU_ZSTICKY_EN
    step("chain_x2",   op_ADDX, 32'h0, 32'h0, 1'b0, 32'h0, 5'b00000);
`else
    step("chain_x2",   op_ADDX, 32'h0, 32'h0, 1'b0, 32'h0, 5'b00100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
